// File: rtl/gray_sequence_checker_pkg.sv
// Shared types and defaults for the Gray sequence checker slice.
// Defines the FSM state encoding and the default word width.
package gray_pkg;

    localparam int GRAY_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

endpackage

// File: rtl/gray_sequence_checker_if.sv
// Sample strobe, Gray input and status outputs of the sequence checker.
// The counter side is the master; the checker is the slave.
interface gray_sequence_checker_if #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
);
    logic             en;
    logic [WIDTH-1:0] gray_in;
    logic [WIDTH-1:0] bin_out;
    logic             locked;
    logic             step_ok;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;

    modport master (
        output en, gray_in,
        input  bin_out, locked, step_ok, err_pulse, err_count
    );

    modport slave (
        input  en, gray_in,
        output bin_out, locked, step_ok, err_pulse, err_count
    );
endinterface

// File: rtl/gray_sequence_checker_gray2bin.sv
// Purely combinational Gray-to-binary converter.
// Each binary bit is the XOR of all Gray bits at and above its position.
module gray2bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] b
);

    // Prefix-XOR via shifts keeps the network free of self-referencing bits.
    always_comb begin
        b = '0;
        for (int i = 0; i < WIDTH; i++) begin
            b[i] = ^(g >> i);
        end
    end

endmodule

// File: rtl/gray_sequence_checker.sv
// Receive-side checker: converts sampled Gray words to binary and verifies
// the stream steps by +1 (mod 2^WIDTH), reporting lock, pulses and errors.
module gray_sequence_checker
    import gray_pkg::*;
#(
    parameter int WIDTH    = GRAY_WIDTH,
    parameter int LOCK_CNT = 3,
    parameter int ERR_W    = 8
) (
    input  logic                   clock,
    input  logic                   Reset,
    gray_sequence_checker_if.slave bus
);

    localparam int                RUN_W  = $clog2(LOCK_CNT + 1);
    localparam logic [RUN_W-1:0]  LOCK_V = RUN_W'(LOCK_CNT);

    logic [WIDTH-1:0] conv_p0;
    logic             match_p0;
    logic [RUN_W-1:0] run_inc_p0;

    state_t           state_p1,    state_n;
    logic [WIDTH-1:0] expected_p1, expected_n;
    logic [RUN_W-1:0] run_p1,      run_n;
    logic [WIDTH-1:0] bin_p1,      bin_n;
    logic             locked_p1,   locked_n;
    logic             step_p1,     step_n;
    logic             err_p1,      err_n;
    logic [ERR_W-1:0] cnt_p1,      cnt_n;

    gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
        .g (bus.gray_in),
        .b (conv_p0)
    );

    assign match_p0   = (conv_p0 == expected_p1);
    assign run_inc_p0 = run_p1 + RUN_W'(1);

    // Stage p0 -> p1: next-state and output decode for the sampled word
    always_comb begin
        state_n    = state_p1;
        expected_n = expected_p1;
        run_n      = run_p1;
        bin_n      = bin_p1;
        locked_n   = locked_p1;
        cnt_n      = cnt_p1;
        step_n     = 1'b0;
        err_n      = 1'b0;

        if (bus.en) begin
            bin_n      = conv_p0;
            expected_n = conv_p0 + WIDTH'(1);
            unique case (state_p1)
                ST_EMPTY: begin
                    run_n   = '0;
                    state_n = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (match_p0) begin
                        step_n = 1'b1;
                        run_n  = run_inc_p0;
                        if (run_inc_p0 == LOCK_V) begin
                            state_n  = ST_LOCKED;
                            locked_n = 1'b1;
                        end
                    end else begin
                        // Resync silently: the new word becomes the reference.
                        run_n = '0;
                    end
                end
                ST_LOCKED: begin
                    if (match_p0) begin
                        step_n = 1'b1;
                    end else begin
                        err_n    = 1'b1;
                        locked_n = 1'b0;
                        run_n    = '0;
                        state_n  = ST_ACQUIRE;
                        if (cnt_p1 != '1) begin
                            cnt_n = cnt_p1 + ERR_W'(1);
                        end
                    end
                end
                default: begin
                    state_n  = ST_EMPTY;
                    run_n    = '0;
                    locked_n = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (Reset) begin
            state_p1    <= ST_EMPTY;
            expected_p1 <= '0;
            run_p1      <= '0;
            bin_p1      <= '0;
            locked_p1   <= 1'b0;
            step_p1     <= 1'b0;
            err_p1      <= 1'b0;
            cnt_p1      <= '0;
        end else begin
            state_p1    <= state_n;
            expected_p1 <= expected_n;
            run_p1      <= run_n;
            bin_p1      <= bin_n;
            locked_p1   <= locked_n;
            step_p1     <= step_n;
            err_p1      <= err_n;
            cnt_p1      <= cnt_n;
        end
    end

    assign bus.bin_out   = bin_p1;
    assign bus.locked    = locked_p1;
    assign bus.step_ok   = step_p1;
    assign bus.err_pulse = err_p1;
    assign bus.err_count = cnt_p1;

endmodule

// File: doc/gray_sequence_checker.md
Name: gray_sequence_checker

Overview:
- Receive-side companion to the 4-bit Gray code counter source.
- Samples the Gray word each enabled cycle and converts it to binary.
- Verifies that the sequence advances by exactly +1, modulo 2^WIDTH.
- Reports lock status, single-cycle error pulses and a saturating error count, so a top-level bench can check the counter autonomously.

Parameters:
WIDTH, 4, Gray/binary word width
LOCK_CNT, 3, consecutive correct steps required to declare lock (>=1)
ERR_W, 8, width of error counter

Ports:
clock  input  1  system clock, rising-edge
Reset  input  1  synchronous, active-high reset
en  input  1  sample strobe; gray_in is evaluated only when en=1
gray_in  input  WIDTH  Gray code word from counter (Q)
bin_out  output  WIDTH  registered binary equivalent of last sampled gray_in
locked  output  1  high while sequence is tracked and locked
step_ok  output  1  1-cycle pulse: sampled word equalled expected value
err_pulse  output  1  1-cycle pulse: sampled word mismatched expected while locked
err_count  output  ERR_W  number of err_pulse events, saturates at all-ones

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-high, sampled on the rising edge of clock.
  - Reset has priority over en.
- Reset values:
  - bin_out=0, locked=0, step_ok=0, err_pulse=0, err_count=0.
  - state=EMPTY, expected=0, run=0.
- Conversion (combinational, internal):
  - b[WIDTH-1]=g[WIDTH-1].
  - b[i]=b[i+1]^g[i] for i<WIDTH-1.
- Latency: all outputs are registered and update on the edge that samples en=1. Sample at edge k is visible after edge k.
- When en=0:
  - All state holds.
  - step_ok and err_pulse are driven 0.
- Expected value: expected <= conv(gray_in)+1 on every sample in any state. Wrap is mod 2^WIDTH, so 1000 (15) is followed by 0000 (0).
- State machine (states in package):
  - EMPTY: first sample loads expected, sets run=0, goes to ACQUIRE. No step_ok and no err_pulse.
  - ACQUIRE, match: step_ok=1, run++. If run+1==LOCK_CNT, go to LOCKED and set locked=1.
  - ACQUIRE, mismatch: run=0, stay in ACQUIRE (resync to the new value). No err_pulse.
  - LOCKED, match: step_ok=1, stay in LOCKED.
  - LOCKED, mismatch: err_pulse=1, err_count++ (saturating), locked=0, run=0, go to ACQUIRE.
- A repeated word (no advance) on an en=1 sample is a mismatch.
- Saturation: err_count at 2^ERR_W-1 stays there. err_pulse still fires.
- Reset mid-operation: returns everything to reset values on that edge. The next sample is treated as a first sample (EMPTY).
- run width: $clog2(LOCK_CNT+1). It never exceeds LOCK_CNT.

Decomposition:
- Package gray_pkg:
  - state enum/localparams ST_EMPTY=2'd0, ST_ACQUIRE=2'd1, ST_LOCKED=2'd2.
  - default WIDTH constant.
- One natural sub-module: gray2bin, purely combinational, parameterized WIDTH, instantiated once. The same block is reused by benches for reference conversion.
- Top-level bench integration: source drives Q -> gray_in; tb drives clock and Reset; en is tied 1.

Test Plan:
1. Reset=1 for 2 cycles, en=1, gray_in=0000 -> all outputs 0 and state EMPTY throughout; after release the first sample 0000 gives bin_out=0, no pulses.
2. Clean sequence 0000,0001,0011,0010 (bin 0..3) with LOCK_CNT=3 -> step_ok on samples 2,3,4; locked=1 after the 4th sample; err_count=0.
3. Wrap while locked: ...,1001(14),1000(15),0000(0) -> step_ok on each; bin_out 14,15,0; locked stays 1; no err_pulse.
4. Locked, then inject 0110 (bin 4) instead of 0011 (bin 2) after 0001 -> err_pulse=1 for one cycle, err_count=1, locked=0. Continuing from 4 (0111,0101,0100) relocks after 3 good steps with no further errors.
5. en gating: locked stream, en=0 for 5 cycles with gray_in changing arbitrarily, then resume with the correct next word -> no pulses during gap; step_ok on resume; locked held.
6. Saturation with ERR_W=2: force 5 mismatches, relocking between each -> err_count goes 1,2,3,3,3 and err_pulse fires all 5 times. Then assert Reset mid-stream -> err_count=0, locked=0 on that edge.
